dds_phase_acc: RTL and testbench

Phase-accumulator address generator for the DDS function generator; sits directly upstream of the coefficient lookup table and drives its 11-bit ROM address every `Fg_CLK` cycle. It integrates a frequency tuning word (FTW), adds a static phase offset and truncates to the address width. FTW changes are accepted through a valid/ready handshake. A change made while running is applied phase-continuously at the next accumulator wrap.

---
 rtl/dds_pkg.sv | 17 +
 rtl/dds_lfsr8.sv | 20 ++
 rtl/dds_phase_acc.sv | 103 ++++++++++
 tb/tb_dds_phase_acc.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS phase-accumulator address generator.
package dds_pkg;

    localparam int ACC_W_DEF  = 32;
    localparam int ADDR_W_DEF = 11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } dds_acc_state_t;

    // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/dds_lfsr8.sv
// 8-bit Fibonacci LFSR used as the phase dither source; holds when en is low.
module dds_lfsr8
    import dds_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] q
);

    logic fb;

    assign fb = ^(q & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= LFSR_SEED;
        else if (en) q <= {q[6:0], fb};
    end

endmodule

// File: rtl/dds_phase_acc.sv
// Phase accumulator feeding the DDS ROM address; FTW changes made while running
// take effect at the next accumulator wrap. Optional dither under DDS_DITHER_EN.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Fg_CLK,
    input  logic              RESETn,
    input  logic [ACC_W-1:0]  ftw_data,
    input  logic              ftw_valid,
    output logic              ftw_ready,
    input  logic [ACC_W-1:0]  phase_ofs,
    input  logic              run,
    input  logic              sync_clr,
    output logic [ADDR_W-1:0] Address,
    output logic              addr_valid,
    output logic              wrap
);

    dds_acc_state_t   st, st_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [ACC_W-1:0] ftw_act, act_nxt;
    logic [ACC_W-1:0] ftw_shd, shd_nxt;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] p;
    logic             xfer, adding, carry;

    assign ftw_ready = (st != PEND);
    assign xfer      = ftw_valid & ftw_ready;
    assign adding    = (st != IDLE) & run;
    assign sum       = {1'b0, acc} + {1'b0, ftw_act};
    assign carry     = adding & sum[ACC_W];

`ifdef DDS_DITHER_EN
    localparam int DSH = ACC_W - ADDR_W - 8;
    logic [7:0] dith;

    dds_lfsr8 u_lfsr (
        .clk   (Fg_CLK),
        .rst_n (RESETn),
        .en    (st != IDLE),
        .q     (dith)
    );

    assign p = acc + phase_ofs + ({{(ACC_W-8){1'b0}}, dith} << DSH);
`else
    assign p = acc + phase_ofs;
`endif

    always_comb begin
        st_nxt  = st;
        act_nxt = ftw_act;
        shd_nxt = ftw_shd;
        acc_nxt = acc;
        if (adding) acc_nxt = sum[ACC_W-1:0];
        if (sync_clr) acc_nxt = '0;
        case (st)
            IDLE: begin
                if (xfer) act_nxt = ftw_data;
                if (run)  st_nxt  = RUN;
            end
            RUN: begin
                // a transfer coinciding with a wrap still waits for the next wrap
                if (xfer) begin
                    shd_nxt = ftw_data;
                    st_nxt  = PEND;
                end else if (!run) begin
                    st_nxt = IDLE;
                end
            end
            PEND: begin
                if (sync_clr || !run || carry) begin
                    act_nxt = ftw_shd;
                    st_nxt  = run ? RUN : IDLE;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            st         <= IDLE;
            acc        <= '0;
            ftw_act    <= '0;
            ftw_shd    <= '0;
            Address    <= '0;
            addr_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            st         <= st_nxt;
            acc        <= acc_nxt;
            ftw_act    <= act_nxt;
            ftw_shd    <= shd_nxt;
            Address    <= p[ACC_W-1 -: ADDR_W];
            addr_valid <= (st != IDLE);
            wrap       <= carry & ~sync_clr;
        end
    end

endmodule

// File: tb/tb_dds_phase_acc.sv
// Randomized and directed bench for dds_phase_acc against a cycle-level reference model.
module tb_dds_phase_acc;

    logic        Fg_CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic [31:0] ftw_data = '0;
    logic        ftw_valid = 1'b0;
    logic        ftw_ready;
    logic [31:0] phase_ofs = '0;
    logic        run = 1'b0;
    logic        sync_clr = 1'b0;
    logic [10:0] Address;
    logic        addr_valid;
    logic        wrap;

    int n_chk = 0;
    int n_err = 0;

    // reference model: phase, active/shadow step, running flag, pending flag
    longint unsigned m_phase, m_step, m_next_step;
    bit              m_running, m_pending;
    int unsigned     m_addr;
    bit              m_wrap, m_av;
    int unsigned     m_dith;

    always #5 Fg_CLK = ~Fg_CLK;

    dds_phase_acc u_dut (
        .Fg_CLK     (Fg_CLK),
        .RESETn     (RESETn),
        .ftw_data   (ftw_data),
        .ftw_valid  (ftw_valid),
        .ftw_ready  (ftw_ready),
        .phase_ofs  (phase_ofs),
        .run        (run),
        .sync_clr   (sync_clr),
        .Address    (Address),
        .addr_valid (addr_valid),
        .wrap       (wrap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_step = 0; m_next_step = 0;
        m_running = 0; m_pending = 0;
        m_addr = 0; m_wrap = 0; m_av = 0;
        m_dith = 1;
    endtask

    // one clock of the model given the inputs presented for the coming edge
    task automatic model_step(input bit v, input longint unsigned d, input longint unsigned o,
                              input bit r, input bit c);
        longint unsigned total, pw;
        bit moving, overflow;
        moving   = m_running && r;
        total    = m_phase + m_step;
        overflow = moving && (total >= 64'h1_0000_0000);
        pw       = m_phase + o;
`ifdef DDS_DITHER_EN
        pw       = pw + (longint'(m_dith) * 8192);
`endif
        m_addr = int'((pw % 64'h1_0000_0000) / 64'd2097152);
        m_wrap = overflow && !c;
        m_av   = m_running;
`ifdef DDS_DITHER_EN
        if (m_running) begin
            bit fb;
            fb = ((m_dith >> 7) ^ (m_dith >> 5) ^ (m_dith >> 4) ^ (m_dith >> 3)) & 1;
            m_dith = ((m_dith * 2) % 256) + fb;
        end
`endif
        if (c)           m_phase = 0;
        else if (moving) m_phase = total % 64'h1_0000_0000;
        if (!m_running) begin
            if (v) m_step = d;
            m_running = r;
        end else if (!m_pending) begin
            if (v) begin
                m_next_step = d;
                m_pending   = 1;
            end else if (!r) begin
                m_running = 0;
            end
        end else if (c || !r || overflow) begin
            m_step    = m_next_step;
            m_pending = 0;
            m_running = r;
        end
    endtask

    // called at a falling edge: check outputs, then present new inputs
    task automatic cyc(input bit v, input logic [31:0] d, input logic [31:0] o,
                       input bit r, input bit c);
        chk("addr", 32'(Address), m_addr);
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("avld", 32'(addr_valid), 32'(m_av));
        chk("rdy",  32'(ftw_ready), 32'(!m_pending));
        ftw_valid = v; ftw_data = d; phase_ofs = o; run = r; sync_clr = c;
        model_step(v, d, o, r, c);
        @(negedge Fg_CLK);
    endtask

    initial begin
        logic [31:0] ofs;
        bit rr;
        model_reset();
        repeat (3) @(negedge Fg_CLK);
        chk("rst_addr", 32'(Address), 0);
        chk("rst_rdy", 32'(ftw_ready), 1);
        RESETn = 1'b1;

        // offset alone moves the address by half a turn
        cyc(0, 0, 32'h8000_0000, 0, 0);
        cyc(0, 0, 32'h8000_0000, 0, 0);
        chk("ofs_half", 32'(Address), 1024);
        cyc(0, 0, 0, 0, 0);

        // load in IDLE, sweep one step per cycle through a full wrap
        cyc(1, 32'h0020_0000, 0, 0, 0);
        for (int i = 0; i < 2100; i++) cyc(0, 0, 0, 1, 0);

        // mid-sweep change: waits for the wrap, then step 2
        cyc(1, 32'h0040_0000, 0, 1, 0);
        chk("pend_rdy", 32'(ftw_ready), 0);
        for (int i = 0; i < 2100; i++) cyc(0, 0, 0, 1, 0);

        // sync_clr while pending promotes the shadow
        cyc(1, 32'h0010_0000, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0);

        // pause and resume
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0);

        // asynchronous reset while pending
        cyc(1, 32'h0100_0000, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        #2 RESETn = 1'b0;
        #1;
        chk("arst_addr", 32'(Address), 0);
        chk("arst_avld", 32'(addr_valid), 0);
        chk("arst_wrap", 32'(wrap), 0);
        chk("arst_rdy", 32'(ftw_ready), 1);
        model_reset();
        ftw_valid = 0; run = 0;
        @(negedge Fg_CLK);
        RESETn = 1'b1;
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0);

        // randomized traffic with large steps so wraps are frequent
        ofs = 0;
        rr  = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) ofs = $urandom;
            if ($urandom_range(0, 15) == 0) rr = ~rr;
            cyc($urandom_range(0, 4) == 0,
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom,
                ofs, rr, $urandom_range(0, 29) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
